// File: rtl/ftdi_rx_buffer.sv
// Host-to-FPGA receive buffer for the FT232H 245 synchronous FIFO link.
// The FTDI clock domain reads bytes off the bus into a dual-clock RAM FIFO.
// The system clock domain pops them. Pointers cross domains in Gray code
// through two-flop synchronisers.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | OE#=1, RD#=1; wait for host data and free space
// OE    | OE#=0, RD#=1 for one cycle of bus turnaround
// READ  | OE#=0, RD#=0; one byte captured per edge while RXF# is low
// DONE  | OE#=0, RD#=1 for one cycle, then release the bus
module ftdi_rx_buffer #(
    parameter int pDataWidth = 8,
    parameter int pDepth     = 16,
    parameter int pAddrWidth = $clog2(pDepth)
) (
    input  logic                  iFtClk,
    input  logic                  iSysClk,
    input  logic                  iRst,
    input  logic                  iFtRxfN,
    input  logic [pDataWidth-1:0] iFtData,
    output logic                  oFtOeN,
    output logic                  oFtRdN,
    input  logic                  iRxRd,
    output logic [pDataWidth-1:0] oRxData,
    output logic                  oRxValid,
    output logic                  oRxAvail,
    output logic [pAddrWidth:0]   oRxCount,
    output logic                  oUnderflow
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OE   = 2'd1;
    localparam logic [1:0] READ = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [pAddrWidth:0] DEPTH_W = (pAddrWidth+1)'(pDepth);
    localparam logic [pAddrWidth:0] ONE_W   = (pAddrWidth+1)'(1);

    function automatic logic [pAddrWidth:0] bin2gray(input logic [pAddrWidth:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [pAddrWidth:0] gray2bin(input logic [pAddrWidth:0] g);
        logic [pAddrWidth:0] b;
        b[pAddrWidth] = g[pAddrWidth];
        for (int i = pAddrWidth - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [pDataWidth-1:0] mem [pDepth];

    // FTDI-domain state
    logic [1:0]            state;
    logic [pAddrWidth:0]   wr_ptr;
    logic [pAddrWidth:0]   wr_gray;
    logic [pAddrWidth:0]   rd_gray_f1;
    logic [pAddrWidth:0]   rd_gray_f2;
    logic [pAddrWidth:0]   rd_sync_bin;
    logic [pAddrWidth:0]   free_ft;
    logic [pAddrWidth:0]   free_after;
    logic                  capture;
    logic                  can_start;
    logic                  can_continue;

    // System-domain state
    logic [pAddrWidth:0]   rd_ptr;
    logic [pAddrWidth:0]   rd_gray;
    logic [pAddrWidth:0]   wr_gray_s1;
    logic [pAddrWidth:0]   wr_gray_s2;
    logic [pAddrWidth:0]   wr_sync_bin;
    logic                  pop;

    // Free space seen from the FTDI side; a stale read pointer only under-reports it.
    always_comb begin
        rd_sync_bin  = gray2bin(rd_gray_f2);
        free_ft      = DEPTH_W - (wr_ptr - rd_sync_bin);
        capture      = (state == READ) && !oFtRdN && !iFtRxfN && !iRst;
        free_after   = free_ft - (capture ? ONE_W : '0);
        can_start    = !iFtRxfN && (free_ft >= ONE_W);
        can_continue = !iFtRxfN && (free_after >= ONE_W);
    end

    // FTDI read sequencer with registered OE#/RD#; the write pointer moves on each capture.
    always_ff @(posedge iFtClk) begin
        if (iRst) begin
            state   <= IDLE;
            oFtOeN  <= 1'b1;
            oFtRdN  <= 1'b1;
            wr_ptr  <= '0;
            wr_gray <= '0;
        end else begin
            if (capture) begin
                wr_ptr  <= wr_ptr + ONE_W;
                wr_gray <= bin2gray(wr_ptr + ONE_W);
            end
            case (state)
                IDLE: begin
                    oFtRdN <= 1'b1;
                    if (can_start) begin
                        state  <= OE;
                        oFtOeN <= 1'b0;
                    end else begin
                        oFtOeN <= 1'b1;
                    end
                end
                OE: begin
                    oFtOeN <= 1'b0;
                    if (can_start) begin
                        state  <= READ;
                        oFtRdN <= 1'b0;
                    end else begin
                        state  <= DONE;
                        oFtRdN <= 1'b1;
                    end
                end
                READ: begin
                    oFtOeN <= 1'b0;
                    if (can_continue) begin
                        oFtRdN <= 1'b0;
                    end else begin
                        state  <= DONE;
                        oFtRdN <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    oFtOeN <= 1'b1;
                    oFtRdN <= 1'b1;
                end
            endcase
        end
    end

    // Bring the system read pointer into the FTDI domain.
    always_ff @(posedge iFtClk) begin
        if (iRst) begin
            rd_gray_f1 <= '0;
            rd_gray_f2 <= '0;
        end else begin
            rd_gray_f1 <= rd_gray;
            rd_gray_f2 <= rd_gray_f1;
        end
    end

    // RAM write port on the FTDI clock.
    always_ff @(posedge iFtClk) begin
        if (capture) begin
            mem[wr_ptr[pAddrWidth-1:0]] <= iFtData;
        end
    end

    // Bring the FTDI write pointer into the system domain.
    always_ff @(posedge iSysClk) begin
        if (iRst) begin
            wr_gray_s1 <= '0;
            wr_gray_s2 <= '0;
        end else begin
            wr_gray_s1 <= wr_gray;
            wr_gray_s2 <= wr_gray_s1;
        end
    end

    // Occupancy seen from the system side; a stale write pointer only under-reports it.
    always_comb begin
        wr_sync_bin = gray2bin(wr_gray_s2);
        oRxCount    = wr_sync_bin - rd_ptr;
        oRxAvail    = (oRxCount != '0);
        pop         = iRxRd && oRxAvail;
    end

    // Pop path: registered RAM read, one-cycle valid pulse, sticky underflow.
    always_ff @(posedge iSysClk) begin
        if (iRst) begin
            rd_ptr     <= '0;
            rd_gray    <= '0;
            oRxData    <= '0;
            oRxValid   <= 1'b0;
            oUnderflow <= 1'b0;
        end else begin
            oRxValid <= pop;
            if (pop) begin
                oRxData <= mem[rd_ptr[pAddrWidth-1:0]];
                rd_ptr  <= rd_ptr + ONE_W;
                rd_gray <= bin2gray(rd_ptr + ONE_W);
            end
            if (iRxRd && !oRxAvail) begin
                oUnderflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ftdi_rx_buffer.sv
// Bench for ftdi_rx_buffer: an FTDI host model feeds bytes, a scoreboard
// queue holds every byte handed to the host and is compared on each pop.
`timescale 1ns/1ps
module tb_ftdi_rx_buffer;

    logic       iFtClk = 1'b0;
    logic       iSysClk = 1'b0;
    logic       iRst = 1'b1;
    logic       iFtRxfN = 1'b1;
    logic [7:0] iFtData = 8'h00;
    logic       oFtOeN;
    logic       oFtRdN;
    logic       iRxRd = 1'b0;
    logic [7:0] oRxData;
    logic       oRxValid;
    logic       oRxAvail;
    logic [4:0] oRxCount;
    logic       oUnderflow;

    int n_tests = 0;
    int n_fail = 0;
    int n_cap = 0;
    int n_rx = 0;
    logic [7:0] host_q[$];
    logic [7:0] exp_q[$];
    logic cap;

    ftdi_rx_buffer #(.pDataWidth(8), .pDepth(16)) dut (
        .iFtClk(iFtClk), .iSysClk(iSysClk), .iRst(iRst),
        .iFtRxfN(iFtRxfN), .iFtData(iFtData),
        .oFtOeN(oFtOeN), .oFtRdN(oFtRdN),
        .iRxRd(iRxRd), .oRxData(oRxData), .oRxValid(oRxValid),
        .oRxAvail(oRxAvail), .oRxCount(oRxCount), .oUnderflow(oUnderflow)
    );

    always #8  iFtClk  = ~iFtClk;
    always #10 iSysClk = ~iSysClk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic host_load(input logic [7:0] b);
        host_q.push_back(b);
        exp_q.push_back(b);
    endtask

    // FTDI host model: a byte leaves the host on each edge with RD# low and RXF# low.
    always @(posedge iFtClk) begin
        cap = !oFtRdN && !iFtRxfN && !iRst;
        #1;
        if (cap && host_q.size() > 0) begin
            void'(host_q.pop_front());
            n_cap++;
        end
        iFtRxfN = (host_q.size() == 0);
        iFtData = (host_q.size() > 0) ? host_q[0] : 8'h00;
    end

    // Scoreboard: every valid byte must match the oldest outstanding host byte.
    always @(negedge iSysClk) begin
        if (oRxValid) begin
            n_rx++;
            if (exp_q.size() == 0) chk("extra_byte", {24'h0, oRxData}, 32'hffff_ffff);
            else chk("rx_data", {24'h0, oRxData}, {24'h0, exp_q.pop_front()});
        end
    end

    task automatic wait_sys_count(input int target, input int budget, input string tag);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge iSysClk);
            if (int'(oRxCount) == target) break;
        end
        chk(tag, oRxCount, target);
    endtask

    task automatic pop_n(input int n);
        @(negedge iSysClk);
        iRxRd = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge iSysClk);
            chk("pop_valid", oRxValid, 1);
        end
        iRxRd = 1'b0;
    endtask

    initial begin
        int base_cap;
        int base_rx;
        int i;
        bit seen;

        // Reset hold with host data waiting.
        for (int k = 0; k < 5; k++) host_load(8'h10 + 8'(k));
        for (int k = 0; k < 5; k++) begin
            @(negedge iSysClk);
            chk("rst_oe", oFtOeN, 1);
            chk("rst_rd", oFtRdN, 1);
            chk("rst_avail", oRxAvail, 0);
            chk("rst_count", oRxCount, 0);
        end
        chk("rst_valid", oRxValid, 0);
        chk("rst_data", oRxData, 0);
        chk("rst_udf", oUnderflow, 0);
        chk("rst_cap", n_cap, 0);
        iRst = 1'b0;

        // OE# falls first, RD# one FTDI cycle later.
        seen = 0;
        for (i = 0; i < 10; i++) begin
            @(posedge iFtClk); #2;
            if (!oFtOeN) begin seen = 1; break; end
        end
        chk("oe_fall", seen, 1);
        chk("rd_still_high", oFtRdN, 1);
        @(posedge iFtClk); #2;
        chk("rd_fall", oFtRdN, 0);
        chk("oe_low", oFtOeN, 0);

        // Burst end: RD# rises, DONE holds OE# low one more cycle.
        seen = 0;
        for (i = 0; i < 20; i++) begin
            @(posedge iFtClk); #2;
            if (oFtRdN) begin seen = 1; break; end
        end
        chk("rd_rise", seen, 1);
        chk("burst_caps", n_cap, 5);
        chk("done_oe_low", oFtOeN, 0);
        @(posedge iFtClk); #2;
        chk("done_oe_high", oFtOeN, 1);

        wait_sys_count(5, 10, "burst_count");
        pop_n(5);
        @(negedge iSysClk);
        chk("burst_empty", oRxAvail, 0);
        chk("burst_valid_off", oRxValid, 0);
        chk("burst_rx", n_rx, 5);

        // Full stall: 40 bytes offered, no pops.
        base_cap = n_cap;
        for (int k = 0; k < 40; k++) host_load(8'h20 + 8'(k));
        for (i = 0; i < 200; i++) begin
            @(posedge iFtClk); #2;
            if (n_cap - base_cap >= 16) break;
        end
        repeat (20) @(posedge iFtClk);
        #2;
        chk("full_caps", n_cap - base_cap, 16);
        chk("full_rd_high", oFtRdN, 1);
        wait_sys_count(16, 10, "full_count");
        pop_n(4);
        repeat (60) @(posedge iFtClk);
        #2;
        chk("resume_caps", n_cap - base_cap, 20);
        wait_sys_count(16, 10, "resume_count");

        // Wrap: 100 more bytes drained with random pop gaps.
        base_rx = n_rx;
        for (int k = 0; k < 100; k++) host_load(8'(k));
        for (i = 0; i < 5000; i++) begin
            @(negedge iSysClk);
            if (n_rx - base_rx >= 136) break;
            iRxRd = oRxAvail && ($urandom_range(0, 3) != 0);
        end
        iRxRd = 1'b0;
        repeat (3) @(negedge iSysClk);
        chk("wrap_rx", n_rx - base_rx, 136);
        chk("wrap_exp_empty", exp_q.size(), 0);
        chk("wrap_avail", oRxAvail, 0);
        chk("wrap_udf", oUnderflow, 0);

        // Underflow: pop while empty.
        @(negedge iSysClk);
        iRxRd = 1'b1;
        @(negedge iSysClk);
        iRxRd = 1'b0;
        chk("udf_valid", oRxValid, 0);
        chk("udf_set", oUnderflow, 1);
        chk("udf_count", oRxCount, 0);
        repeat (4) @(negedge iSysClk);
        chk("udf_sticky", oUnderflow, 1);

        // Mid-burst reset after 3 captures.
        base_cap = n_cap;
        for (int k = 0; k < 8; k++) host_load(8'h40 + 8'(k));
        for (i = 0; i < 40; i++) begin
            @(posedge iFtClk); #2;
            if (n_cap - base_cap >= 3) break;
        end
        chk("mid_caps", n_cap - base_cap, 3);
        chk("mid_rd_low", oFtRdN, 0);
        iRst = 1'b1;
        host_q.delete();
        exp_q.delete();
        @(posedge iFtClk); #2;
        chk("mid_rst_rd", oFtRdN, 1);
        chk("mid_rst_oe", oFtOeN, 1);
        chk("mid_no_cap", n_cap - base_cap, 3);
        repeat (5) @(negedge iSysClk);
        chk("mid_rst_count", oRxCount, 0);
        chk("mid_rst_udf", oUnderflow, 0);
        iRst = 1'b0;

        // Fresh 2-byte burst after reset.
        base_rx = n_rx;
        host_load(8'h55);
        host_load(8'h66);
        wait_sys_count(2, 40, "fresh_count");
        pop_n(2);
        repeat (2) @(negedge iSysClk);
        chk("fresh_rx", n_rx - base_rx, 2);
        chk("fresh_empty", oRxAvail, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ftdi_rx_buffer.md
Name: ftdi_rx_buffer

Overview:
- Host-to-FPGA path of the FTDI FT232H 245 synchronous FIFO link; the opposite direction to the FPGA-to-host transmit buffer.
- Drains bytes from the FTDI chip on the 60 MHz FTDI clock and stores them in a dual-clock RAM FIFO.
- FPGA logic pops the bytes on the 48 MHz system clock.
- Crosses clock domains with Gray-coded pointers and 2-flop synchronisers.

Parameters:
pDataWidth, 8, byte width of FTDI bus and FIFO entries
pDepth, 16, FIFO entries; power of 2, 4..512
pAddrWidth, $clog2(pDepth), RAM address width (derived; do not override)

Ports:
iFtClk  input  1  60 MHz clock from the FTDI chip
iSysClk  input  1  48 MHz system clock
iRst  input  1  reset; synchronous, active-high; sampled independently in each clock domain
iFtRxfN  input  1  FTDI RXF#; low = host data available
iFtData  input  pDataWidth  FTDI data bus, input half; tri-state is handled at top level
oFtOeN  output  1  FTDI OE#; low = FTDI drives the bus
oFtRdN  output  1  FTDI RD#; low = read strobe
iRxRd  input  1  sys-domain pop request
oRxData  output  pDataWidth  popped byte; registered
oRxValid  output  1  oRxData valid; 1-cycle pulse
oRxAvail  output  1  FIFO not empty (sys view)
oRxCount  output  pAddrWidth+1  occupancy (sys view)
oUnderflow  output  1  sticky; set by a pop while empty

Behaviour:
- Reset: iRst must be held for at least 3 iSysClk cycles. Each domain clears its own state on its own clock edge.
- Reset values: oFtOeN=1, oFtRdN=1, oRxData=0, oRxValid=0, oRxAvail=0, oRxCount=0, oUnderflow=0; all pointers and synchronisers = 0; FSM = IDLE.
- Reset mid-burst: OE# and RD# go high on the next iFtClk edge. FIFO contents are discarded.
- Pointers: pAddrWidth+1 bits each, binary plus Gray copy. Gray copies are registered before crossing; each crossing uses 2 flops.
- FTDI-domain free space: freeFt = pDepth - (wrPtr - rdPtrSyncFt), modulo 2^(pAddrWidth+1).
- Sys-domain occupancy: oRxCount = wrPtrSyncSys - rdPtr.
- Stale synchronised values are conservative in both domains: under-report free space and under-report count.
- FTDI FSM (iFtClk), all outputs registered:
  - IDLE: OE#=1, RD#=1. Go to OE when iFtRxfN=0 and freeFt>=1.
  - OE: OE#=0, RD#=1 for exactly 1 cycle (bus turnaround). Go to READ with RD#=0 if iFtRxfN=0 and freeFt>=1; else go to DONE.
  - READ: OE#=0. Capture occurs on each edge where registered oFtRdN=0 and iFtRxfN=0.
    - Capture: write iFtData to RAM[wrPtr[pAddrWidth-1:0]] and increment wrPtr on the same edge.
    - Stay with RD#=0 while iFtRxfN=0 and (freeFt - capture)>=1. Otherwise set RD#=1 and go to DONE.
  - DONE: RD#=1, OE#=0 for 1 cycle, then OE#=1 and go to IDLE.
- Overflow is impossible by construction. The RD# continue check counts the write on the current edge.
- RXF# rising mid-burst: no capture on that edge; exit via DONE.
- Sys side (iSysClk):
  - Pop accepted when iRxRd=1 and oRxAvail=1. Read RAM[rdPtr], increment rdPtr.
  - oRxData and oRxValid=1 appear on the next cycle (latency 1). Back-to-back pops give 1 byte per cycle.
  - iRxRd while empty: ignored, pointer unchanged, oUnderflow set until reset.
- oRxAvail = (oRxCount != 0).
- Write-to-visible latency: captured byte shows in oRxAvail within 3 iSysClk cycles after the capturing iFtClk edge.
- Wrap-around: pointers roll over mod 2^(pAddrWidth+1). The full/empty distinction uses the MSB.
- RAM: inferred simple dual-port RAM (write on iFtClk, registered read on iSysClk), pDepth x pDataWidth.

Test Plan:
- Reset hold: iRst for 5 iSysClk cycles with iFtRxfN=0 -> OE#/RD# stay 1, oRxAvail=0, oRxCount=0. After release -> OE# falls, then RD# falls 1 cycle later.
- Burst: FTDI model presents 0x10..0x14 (5 bytes), then RXF# high -> exactly 5 captures; DONE keeps OE# low 1 cycle. Sys pops 5 back-to-back -> oRxData 0x10..0x14 with oRxValid on 5 consecutive cycles; then oRxAvail=0.
- Full stall: pDepth=16, host has 40 bytes, no pops -> RD# rises after the 16th capture; oRxCount=16; no byte lost or duplicated. Pop 4 -> reader resumes and captures exactly 4 more.
- Wrap: stream 100 bytes (incrementing pattern) with random pop gaps -> all 100 received in order; pointers wrap at least 6 times.
- Underflow: pop while empty -> oRxValid stays 0, oUnderflow=1 and stays 1 until iRst.
- Mid-burst reset: assert iRst during READ after 3 captures -> RD#=1, OE#=1 next iFtClk edge; oRxCount=0; a fresh 2-byte burst after release pops correctly.
